clk_div_monitor: RTL and testbench

Measures a divided clock, such as the output of the team's odd/even dividers, inside the fast source-clock domain. It reports period and high time in source-clock cycles and declares lock once the divide ratio has matched the expected value for a programmable number of consecutive periods. It flags a stuck divided clock and ratio errors after lock. The block sits on the receiving end of any divider output and serves as an in-system checker and a bring-up aid.

---
 rtl/clk_div_monitor_if.sv | 13 +
 rtl/clk_div_monitor.sv | 100 ++++++++++
 tb/tb_clk_div_monitor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: enable/clock-under-test inputs and measurement outputs of clk_div_monitor.
interface clk_div_monitor_if #(parameter int CW = 16);
    logic          en;
    logic          clk_in;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          locked;
    logic          err_stuck;
    logic          err_ratio;
    modport master (output en, clk_in, input period, high_time, meas_valid, locked, err_stuck, err_ratio);
    modport slave (input en, clk_in, output period, high_time, meas_valid, locked, err_stuck, err_ratio);
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures a divided clock in clk cycles, locks on the expected ratio, flags stuck/ratio errors.
module clk_div_monitor #(
    parameter int N_EXP    = 7,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int CW       = 16
) (
    input logic clk,
    input logic rst,
    clk_div_monitor_if.slave bus
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CW:0] lo_lim = (CW+1)'(N_EXP > TOL ? N_EXP - TOL : 0);
    localparam logic [CW:0] hi_lim = (CW+1)'(N_EXP + TOL);
    localparam logic [CW-1:0] stuck_at = CW'(2 * N_EXP);

    typedef enum logic [1:0] {IDLE, ARM, TRACK, LOCKED} state_t;

    state_t state, state_n;
    logic s1, s2, s3, rise, good, cap, stuck, bad, hold;
    logic [CW-1:0] cnt, hcnt;
    logic [GW-1:0] good_cnt, good_n;

    assign rise = s2 & ~s3;
    assign good = ({1'b0, cnt} >= lo_lim) && ({1'b0, cnt} <= hi_lim);
    assign hold = !bus.en || state == IDLE;

    // A rise always takes priority over the stuck timeout in the same cycle
    always_comb begin
        state_n = state;
        good_n = good_cnt;
        cap = 1'b0;
        stuck = 1'b0;
        bad = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            good_n = '0;
        end else begin
            case (state)
                IDLE: state_n = ARM;
                ARM: state_n = rise ? TRACK : ARM;
                TRACK:
                    if (rise) begin
                        cap = 1'b1;
                        good_n = good ? good_cnt + 1'b1 : '0;
                        state_n = (good && good_cnt == GW'(LOCK_CNT - 1)) ? LOCKED : TRACK;
                    end else if (cnt == stuck_at) begin
                        stuck = 1'b1;
                        good_n = '0;
                        state_n = ARM;
                    end
                LOCKED:
                    if (rise) begin
                        cap = 1'b1;
                        bad = !good;
                        good_n = good ? good_cnt : '0;
                        state_n = good ? LOCKED : TRACK;
                    end else if (cnt == stuck_at) begin
                        stuck = 1'b1;
                        good_n = '0;
                        state_n = ARM;
                    end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            state <= IDLE;
            good_cnt <= '0;
            cnt <= '0;
            hcnt <= '0;
            bus.period <= '0;
            bus.high_time <= '0;
            bus.meas_valid <= 1'b0;
            bus.locked <= 1'b0;
            bus.err_stuck <= 1'b0;
            bus.err_ratio <= 1'b0;
        end else begin
            s1 <= bus.clk_in;
            s2 <= s1;
            s3 <= s2;
            state <= state_n;
            good_cnt <= good_n;
            cnt <= hold ? '0 : rise ? CW'(1) : (&cnt ? cnt : cnt + 1'b1);
            hcnt <= hold ? '0 : rise ? CW'(s2) : (&hcnt ? hcnt : hcnt + CW'(s2));
            bus.meas_valid <= cap;
            bus.locked <= state_n == LOCKED;
            bus.err_stuck <= stuck;
            bus.err_ratio <= bad;
            if (cap) begin
                bus.period <= cnt;
                bus.high_time <= hcnt;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed checks of lock, tolerance, stuck, reset, enable and saturation behaviour.
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int nmv = 0, nst = 0, ner = 0, nmv4 = 0, nst4 = 0;
    int last_p = 0, last_h = 0;
    int snap, snap2;

    clk_div_monitor_if #(.CW(16)) bus ();
    clk_div_monitor_if #(.CW(4)) bus4 ();

    clk_div_monitor #(.N_EXP(7), .TOL(1), .LOCK_CNT(4), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    clk_div_monitor #(.N_EXP(7), .TOL(1), .LOCK_CNT(4), .CW(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk cycle with clk_in driven to b; outputs observed 1 time unit after the edge
    task automatic step(input logic b);
        bus.clk_in = b;
        bus4.clk_in = b;
        @(posedge clk);
        #1;
        if (bus.meas_valid) begin
            nmv++;
            last_p = int'(bus.period);
            last_h = int'(bus.high_time);
        end
        nst += int'(bus.err_stuck);
        ner += int'(bus.err_ratio);
        nmv4 += int'(bus4.meas_valid);
        nst4 += int'(bus4.err_stuck);
    endtask

    task automatic wave(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.clk_in = 1'b0;
        bus4.en = 1'b0;
        bus4.clk_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_period", bus.period, 0);
        chk("rst_high", bus.high_time, 0);
        chk("rst_flags", {bus.meas_valid, bus.locked, bus.err_stuck, bus.err_ratio}, 0);
        // Lock with the nominal 4-high / 3-low waveform
        bus.en = 1'b1;
        repeat (3) step(1'b0);
        wave(4, 3);
        chk("first_rise_discarded", nmv, 0);
        wave(4, 3);
        chk("meas1_count", nmv, 1);
        chk("meas1_period", last_p, 7);
        chk("meas1_high", last_h, 4);
        chk("meas1_unlocked", bus.locked, 0);
        wave(4, 3);
        wave(4, 3);
        chk("meas3_unlocked", bus.locked, 0);
        step(1'b1);
        step(1'b1);
        chk("lock_latency_early", {bus.meas_valid, bus.locked}, 0);
        step(1'b1);
        chk("lock_latency_mv", bus.meas_valid, 1);
        chk("lock_latency_locked", bus.locked, 1);
        step(1'b1);
        repeat (3) step(1'b0);
        // Periods 6 and 8 keep lock
        wave(4, 2);
        wave(4, 4);
        chk("tol6_period", last_p, 6);
        chk("tol6_locked", bus.locked, 1);
        wave(4, 3);
        chk("tol8_period", last_p, 8);
        chk("tol8_locked", bus.locked, 1);
        chk("tol_no_ratio_err", ner, 0);
        // Period 9 while locked, then relock through 6, 8, 7, 7
        wave(4, 5);
        wave(4, 2);
        chk("ratio9_err", ner, 1);
        chk("ratio9_period", last_p, 9);
        chk("ratio9_unlocked", bus.locked, 0);
        wave(4, 4);
        chk("relock_p6", last_p, 6);
        wave(4, 3);
        chk("relock_p8", last_p, 8);
        wave(4, 3);
        chk("relock_3_unlocked", bus.locked, 0);
        wave(4, 3);
        chk("relock_4_locked", bus.locked, 1);
        chk("relock_ratio_count", ner, 1);
        // Stuck low while locked
        snap = nmv;
        repeat (30) step(1'b0);
        chk("stuck_count", nst, 1);
        chk("stuck_unlocked", bus.locked, 0);
        chk("stuck_no_meas", nmv, snap);
        wave(4, 3);
        chk("stuck_rearm_discard", nmv, snap);
        wave(4, 3);
        wave(4, 3);
        wave(4, 3);
        chk("stuck_relock_3", bus.locked, 0);
        wave(4, 3);
        chk("stuck_relock_4", bus.locked, 1);
        chk("stuck_relock_period", last_p, 7);
        // Asynchronous reset between clk edges
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_period", bus.period, 0);
        chk("async_rst_high", bus.high_time, 0);
        chk("async_rst_flags", {bus.meas_valid, bus.locked, bus.err_stuck, bus.err_ratio}, 0);
        #2;
        rst = 1'b0;
        snap = nmv;
        wave(4, 3);
        chk("post_rst_discard", nmv, snap);
        wave(4, 3);
        chk("post_rst_meas", nmv, snap + 1);
        chk("post_rst_period", last_p, 7);
        wave(4, 3);
        wave(4, 3);
        wave(4, 3);
        chk("post_rst_locked", bus.locked, 1);
        // Enable drop while locked holds the measurement
        bus.en = 1'b0;
        step(1'b0);
        chk("en_drop_unlocked", bus.locked, 0);
        chk("en_drop_period_held", bus.period, 7);
        chk("en_drop_high_held", bus.high_time, 4);
        bus.en = 1'b1;
        repeat (2) step(1'b0);
        wave(4, 3);
        wave(4, 3);
        snap = nmv;
        step(1'b1);
        step(1'b1);
        bus.en = 1'b0;
        step(1'b1);
        chk("en_vs_rise_no_mv", bus.meas_valid, 0);
        chk("en_vs_rise_count", nmv, snap);
        step(1'b1);
        repeat (3) step(1'b0);
        // Rise coinciding with cnt == 14 is measured, not stuck
        bus.en = 1'b1;
        repeat (2) step(1'b0);
        snap = nst;
        snap2 = ner;
        wave(4, 3);
        wave(4, 10);
        wave(4, 3);
        chk("edge14_period", last_p, 14);
        chk("edge14_no_stuck", nst, snap);
        chk("edge14_track_no_ratio", ner, snap2);
        chk("edge14_unlocked", bus.locked, 0);
        // Narrow counters: 20-cycle period after the discarded rise
        bus4.en = 1'b1;
        repeat (3) step(1'b0);
        wave(4, 16);
        wave(4, 3);
        chk("sat_stuck_once", nst4, 1);
        chk("sat_no_meas", nmv4, 0);
        chk("sat_period_zero", bus4.period, 0);
        chk("sat_unlocked", bus4.locked, 0);
        wave(4, 3);
        chk("sat_meas_after", nmv4, 1);
        chk("sat_period7", bus4.period, 7);
        chk("sat_high4", bus4.high_time, 4);
        chk("sat_stuck_total", nst4, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
